// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_drain
// Purpose  : UART transmitter that drains a show-ahead byte FIFO. It captures
//            and pops the FIFO head in the same cycle, then sends a
//            start / data (LSB first) / optional parity / stop frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
  parameter int CLKDIV    = 16,  // clock cycles per bit period (>= 2)
  parameter int DWIDTH    = 8,   // data bits per frame
  parameter int PARITY    = 0,   // 0 = none, 1 = even, 2 = odd
  parameter int STOP_BITS = 1    // 1 or 2
) (
  input  logic              clk_i,
  input  logic              rst_i,       // synchronous, active-low
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_out,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy
);

  localparam int BW = $clog2(CLKDIV);
  localparam int CW = $clog2(DWIDTH + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKDIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DWIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == 2);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t            state_q;
  logic [BW-1:0]     baud_q;
  logic [CW-1:0]     bit_q;
  logic [DWIDTH-1:0] shift_q;
  logic              par_q;
  logic              tx_q;

  logic              load;
  logic              baud_end;
  logic              last_stop;
  logic [BW-1:0]     baud_d;
  logic [DWIDTH-1:0] shift_d;

  assign load      = tx_en & ~fifo_empty;
  assign baud_end  = (baud_q == BAUD_LAST);
  assign last_stop = (state_q == S_STOP) && baud_end && (bit_q == STOP_LAST);
  assign baud_d    = baud_end ? '0 : baud_q + BW'(1);
  assign shift_d   = shift_q >> 1;

  // Pop strobe: show-ahead FIFO lets capture and pop share one cycle; the
  // final stop cycle also reloads so consecutive frames have no idle gap.
  assign fifo_pop = rst_i & load & ((state_q == S_IDLE) | last_stop);
  assign tx       = tx_q;
  assign busy     = (state_q != S_IDLE);

  // Frame sequencer: bit timing, shift register and registered line level.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          if (load) begin
            shift_q <= fifo_out;
            par_q   <= ^fifo_out;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end

        S_START: begin
          baud_q <= baud_d;
          if (baud_end) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end

        S_DATA: begin
          baud_q <= baud_d;
          if (baud_end) begin
            shift_q <= shift_d;
            if (bit_q == DATA_LAST) begin
              bit_q <= '0;
              if (HAS_PAR) begin
                state_q <= S_PARITY;
                tx_q    <= par_q ^ PAR_INV;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + CW'(1);
              tx_q  <= shift_d[0];
            end
          end
        end

        S_PARITY: begin
          baud_q <= baud_d;
          if (baud_end) begin
            state_q <= S_STOP;
            bit_q   <= '0;
            tx_q    <= 1'b1;
          end
        end

        S_STOP: begin
          baud_q <= baud_d;
          if (baud_end) begin
            if (bit_q == STOP_LAST) begin
              bit_q <= '0;
              if (load) begin
                shift_q <= fifo_out;
                par_q   <= ^fifo_out;
                state_q <= S_START;
                tx_q    <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + CW'(1);
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
